// File: rtl/network_perf_pkg.sv
// Shared definitions for the network performance monitor: event index map,
// arm trigger event and the default last-only mask.
package network_perf_pkg;

    typedef enum logic [2:0] {
        EV_WR_CMD  = 3'd0,
        EV_WR_STS  = 3'd1,
        EV_WR_DATA = 3'd2,
        EV_RD_CMD  = 3'd3,
        EV_RD_STS  = 3'd4,
        EV_RD_DATA = 3'd5
    } perf_ev_e;

    localparam perf_ev_e ARM_EV = EV_WR_CMD;

    // Data streams count packets (last beats), everything else counts every beat.
    localparam logic [5:0] LAST_ONLY_DEFAULT = 6'b100100;

endpackage

// File: rtl/network_perf_monitor_counter.sv
// Saturating event counter with sticky saturation flag and a snapshot register
// that captures count+inc and restarts the count in the same cycle.
module perf_sat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 sys_reset,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] snap_cnt,
    output logic                 snap_sat
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic                 at_max;

    always_comb begin
        at_max = &cnt_q;
        cnt_d  = (inc && !at_max) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        // Sticky flag marks that at least one event was lost to saturation.
        sat_d  = sat_q | (inc & at_max);
    end

    always_ff @(posedge aclk or posedge sys_reset) begin
        if (sys_reset) begin
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            snap_cnt <= '0;
            snap_sat <= 1'b0;
        end else if (clr) begin
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            snap_cnt <= '0;
            snap_sat <= 1'b0;
        end else if (snap) begin
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            snap_cnt <= cnt_d;
            snap_sat <= sat_d;
        end else begin
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: rtl/network_perf_monitor.sv
// Windowed handshake-statistics monitor: counts completed transfers per channel
// and event over a programmable cycle window and publishes an atomic snapshot.
module network_perf_monitor
    import network_perf_pkg::*;
#(
    parameter int unsigned        NUM_CH      = 2,
    parameter int unsigned        NUM_EV      = 6,
    parameter int unsigned        CNT_WIDTH   = 32,
    parameter int unsigned        WIN_WIDTH   = 32,
    parameter int unsigned        WIN_DEFAULT = 750000000,
    parameter logic [NUM_EV-1:0]  LAST_ONLY   = LAST_ONLY_DEFAULT
) (
    input  logic                                aclk,
    input  logic                                sys_reset,
    input  logic [NUM_CH*NUM_EV-1:0]            ev_valid,
    input  logic [NUM_CH*NUM_EV-1:0]            ev_ready,
    input  logic [NUM_CH*NUM_EV-1:0]            ev_last,
    input  logic [WIN_WIDTH-1:0]                win_len,
    input  logic                                continuous,
    input  logic                                arm_on_event,
    input  logic                                sw_start,
    input  logic                                sw_stop,
    input  logic                                clear,
    output logic                                running,
    output logic                                snap_valid,
    output logic                                snap_partial,
    output logic [WIN_WIDTH-1:0]                snap_cycles,
    output logic [NUM_CH*NUM_EV*CNT_WIDTH-1:0]  snap_cnt,
    output logic [NUM_CH*NUM_EV-1:0]            snap_sat
);

    localparam int unsigned NUM_TAP = NUM_CH * NUM_EV;
    localparam int unsigned ARM_IDX = 32'(ARM_EV);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WIN_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_WIDTH-1:0] len_q, len_d;
    logic [WIN_WIDTH-1:0] cycles_q, cycles_d;
    logic                 valid_q, valid_d;
    logic                 partial_q, partial_d;

    logic [NUM_TAP-1:0]   hs;
    logic                 arm_hit, trigger, stop_evt, end_evt, count_en, snap_take;
    logic [WIN_WIDTH-1:0] eff_len, cur_cnt;

    for (genvar i = 0; i < NUM_TAP; i++) begin : g_hs
        assign hs[i] = ev_valid[i] & ev_ready[i] & (ev_last[i] | ~LAST_ONLY[i % NUM_EV]);
    end

    always_comb begin
        arm_hit = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            arm_hit = arm_hit | hs[ch*NUM_EV + ARM_IDX];
        end
        eff_len  = (win_len == '0) ? WIN_WIDTH'(1) : win_len;
        // win_cnt_q holds completed window cycles, so cur_cnt is this cycle's index.
        cur_cnt  = win_cnt_q + WIN_WIDTH'(1);
        trigger  = (state_q == ST_IDLE) && (sw_start || (arm_on_event && arm_hit));
        stop_evt = !clear && (state_q == ST_RUN) && sw_stop;
        // A one-cycle window closes in its own arm cycle.
        end_evt  = !clear && !stop_evt &&
                   (((state_q == ST_RUN) && (cur_cnt == len_q)) ||
                    (trigger && (eff_len == WIN_WIDTH'(1))));
        count_en  = (state_q == ST_RUN) || trigger;
        snap_take = stop_evt || end_evt;
    end

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        len_d     = len_q;
        cycles_d  = cycles_q;
        valid_d   = 1'b0;
        partial_d = partial_q;
        if (clear) begin
            state_d   = ST_IDLE;
            win_cnt_d = '0;
            cycles_d  = '0;
            partial_d = 1'b0;
        end else if (stop_evt) begin
            state_d   = ST_IDLE;
            win_cnt_d = '0;
            cycles_d  = cur_cnt;
            valid_d   = 1'b1;
            partial_d = 1'b1;
        end else if (end_evt) begin
            win_cnt_d = '0;
            cycles_d  = trigger ? eff_len : len_q;
            valid_d   = 1'b1;
            partial_d = 1'b0;
            if (continuous) begin
                state_d = ST_RUN;
                len_d   = eff_len;
            end else begin
                state_d = ST_IDLE;
                if (trigger) len_d = eff_len;
            end
        end else if (trigger) begin
            state_d   = ST_RUN;
            win_cnt_d = WIN_WIDTH'(1);
            len_d     = eff_len;
        end else if (state_q == ST_RUN) begin
            win_cnt_d = cur_cnt;
        end
    end

    always_ff @(posedge aclk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            len_q     <= WIN_WIDTH'(WIN_DEFAULT);
            cycles_q  <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            len_q     <= len_d;
            cycles_q  <= cycles_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
        end
    end

    for (genvar i = 0; i < NUM_TAP; i++) begin : g_cnt
        perf_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .aclk      (aclk),
            .sys_reset (sys_reset),
            .inc       (hs[i] & count_en),
            .clr       (clear),
            .snap      (snap_take),
            .snap_cnt  (snap_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .snap_sat  (snap_sat[i])
        );
    end

    assign running      = (state_q == ST_RUN);
    assign snap_valid   = valid_q;
    assign snap_partial = partial_q;
    assign snap_cycles  = cycles_q;

endmodule
